// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank responder: NUM_REGS read/write registers with byte strobes,
// independent write and read FSMs, and a flat export of all register contents.
module axil_reg_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic                           dbg_wstate_o,
    output logic                           dbg_rstate_o
);
    // Handshake rule on every channel: a transfer happens on a rising edge where
    // valid and ready are both 1; valid and payload never change while waiting for ready.

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_COLLECT = 1'b0, W_RESP = 1'b1 } wstate_e;
    typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } rstate_e;

    wstate_e                 wstate_q;
    rstate_e                 rstate_q;
    logic                    aw_full_q, w_full_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic                    awready_q, wready_q, bvalid_q;
    logic [1:0]              bresp_q;
    logic                    arready_q, rvalid_q;
    logic [1:0]              rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic                    aw_full_d, w_full_d;
    logic [ADDR_WIDTH-1:0]   awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [STRB_W-1:0]       wstrb_d;
    logic [IDX_W-1:0]        wr_idx, rd_idx;
    logic [NUM_REGS-1:0]     wr_hit;
    logic                    wr_in_range, rd_in_range;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic                    unused_addr_lsbs;

    // A channel arriving in the commit cycle is used directly, not via its buffer.
    always_comb begin
        aw_hs       = s_axi_awvalid & awready_q;
        w_hs        = s_axi_wvalid & wready_q;
        ar_hs       = s_axi_arvalid & arready_q;
        aw_full_d   = aw_full_q | aw_hs;
        w_full_d    = w_full_q | w_hs;
        awaddr_d    = aw_hs ? s_axi_awaddr : awaddr_q;
        wdata_d     = w_hs ? s_axi_wdata : wdata_q;
        wstrb_d     = w_hs ? s_axi_wstrb : wstrb_q;
        commit      = (wstate_q == W_COLLECT) & aw_full_d & w_full_d;
        wr_idx      = awaddr_d[ADDR_WIDTH-1:2];
        rd_idx      = s_axi_araddr[ADDR_WIDTH-1:2];
        wr_hit      = '0;
        rd_in_range = 1'b0;
        rd_val      = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_idx == IDX_W'(k)) wr_hit[k] = 1'b1;
            if (rd_idx == IDX_W'(k)) begin
                rd_in_range = 1'b1;
                rd_val      = regs_q[k];
            end
        end
        wr_in_range = |wr_hit;
    end

    assign unused_addr_lsbs = ^{awaddr_d[1:0], s_axi_araddr[1:0]};

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wstate_q  <= W_COLLECT;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (wstate_q)
                W_COLLECT: begin
                    if (aw_hs) awaddr_q <= s_axi_awaddr;
                    if (w_hs) begin
                        wdata_q <= s_axi_wdata;
                        wstrb_q <= s_axi_wstrb;
                    end
                    if (commit) begin
                        aw_full_q <= 1'b1;
                        w_full_q  <= 1'b1;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        wstate_q  <= W_RESP;
                    end else begin
                        aw_full_q <= aw_full_d;
                        w_full_q  <= w_full_d;
                        awready_q <= ~aw_full_d;
                        wready_q  <= ~w_full_d;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        aw_full_q <= 1'b0;
                        w_full_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_COLLECT;
                    end
                end
                default: wstate_q <= W_COLLECT;
            endcase
        end
    end

    // Reads sample regs_q before this edge's commit lands, so a colliding read sees the old value.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else if (commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_hit[k] && wstrb_d[b]) regs_q[k][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_q   <= rd_in_range ? rd_val : '0;
                        rresp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign dbg_wstate_o  = wstate_q;
    assign dbg_rstate_o  = rstate_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: a shadow register model predicts each response, which is
// queued at drive time and popped when the DUT presents B or R.
module tb_axil_reg_slave;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 8;

    logic          clk, rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready;
    logic [NR*DW-1:0] regs;
    logic          dbg_w, dbg_r;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0]   model_q [NR];
    logic [1:0]      exp_b_q [$];
    logic [DW+1:0]   exp_r_q [$];

    axil_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .regs_o(regs), .dbg_wstate_o(dbg_w), .dbg_rstate_o(dbg_r)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < NR; k++)
            check($sformatf("%s_reg%0d", tag, k), 64'(regs[k*DW +: DW]), 64'(model_q[k]));
    endtask

    function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                               input logic [3:0] s);
        int i;
        i = int'(a[AW-1:2]);
        if (i >= NR) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (s[b]) model_q[i][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [DW+1:0] model_read(input logic [AW-1:0] a);
        int i;
        i = int'(a[AW-1:2]);
        if (i >= NR) return {2'b10, 32'h0};
        return {2'b00, model_q[i]};
    endfunction

    // driver tasks; each starts and ends just after a falling edge
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input int lead, input int bhold);
        int cyc, aw_start, w_start;
        logic aw_done, w_done, aw_fire, w_fire;
        logic [1:0] exp;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        exp_b_q.push_back(model_write(a, d, s));
        awaddr = a; wdata = d; wstrb = s;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc >= aw_start) awvalid = 1'b1;
            if (!w_done && cyc >= w_start) wvalid = 1'b1;
            check("b_early", 64'(bvalid), 64'd0);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_fire) begin wvalid = 1'b0; w_done = 1'b1; end
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("aw_w_accept", 64'(aw_done && w_done), 64'd1);
        check("b_latency", 64'(bvalid), 64'd1);
        check_regs("wr");
        cyc = 0;
        while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
        exp = exp_b_q.pop_front();
        check("bresp", 64'(bresp), 64'(exp));
        for (int i = 0; i < bhold; i++) begin
            @(negedge clk);
            check("b_hold_valid", 64'(bvalid), 64'd1);
            check("b_hold_resp", 64'(bresp), 64'(exp));
            check("b_hold_readies", 64'({awready, wready}), 64'd0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("b_done_valid", 64'(bvalid), 64'd0);
        check("b_done_readies", 64'({awready, wready}), 64'd3);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int rhold);
        int cyc;
        logic fired, ar_fire;
        logic [DW+1:0] exp;
        exp_r_q.push_back(model_read(a));
        araddr = a; arvalid = 1'b1;
        fired = 1'b0; cyc = 0;
        while (!fired && cyc < 40) begin
            ar_fire = arvalid && arready;
            @(negedge clk);
            if (ar_fire) fired = 1'b1;
            cyc++;
        end
        arvalid = 1'b0;
        check("ar_accept", 64'(fired), 64'd1);
        check("r_latency", 64'(rvalid), 64'd1);
        exp = exp_r_q.pop_front();
        check("rdata_rresp", 64'({rresp, rdata}), 64'(exp));
        for (int i = 0; i < rhold; i++) begin
            @(negedge clk);
            check("r_hold_valid", 64'(rvalid), 64'd1);
            check("r_hold_payload", 64'({rresp, rdata}), 64'(exp));
            check("r_hold_arready", 64'(arready), 64'd0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("r_done_valid", 64'(rvalid), 64'd0);
        check("r_done_arready", 64'(arready), 64'd1);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [DW+1:0] er;
        logic [1:0]    eb;
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        for (int k = 0; k < NR; k++) model_q[k] = '0;

        // reset for 3 cycles
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check_regs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_readies", 64'({awready, wready, arready}), 64'd7);
        do_read(8'h00, 0);

        // full write, same-cycle AW/W
        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        check("full_wr_reg1", 64'(regs[63:32]), 64'hDEADBEEF);
        do_read(8'h04, 0);

        // partial strobe, W two cycles ahead of AW
        do_write(8'h04, 32'h11223344, 4'b0101, 2, 0);
        check("partial_reg1", 64'(regs[63:32]), 64'hDE22BE44);

        // out of range
        do_write(8'h20, 32'h00000055, 4'hF, 0, 0);
        do_read(8'h3C, 0);

        // backpressure, AW ahead of W
        do_write(8'h0C, 32'hCAFEF00D, 4'hF, -1, 5);
        do_read(8'h0C, 5);
        do_write(8'h08, 32'h12345678, 4'hF, 0, 0);

        // random traffic
        for (int n = 0; n < 24; n++) begin
            ra = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1)
                do_write(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2,
                         $urandom_range(0, 2));
            else
                do_read(ra, $urandom_range(0, 2));
        end

        // same-register read and write commit in one cycle
        exp_r_q.push_back(model_read(8'h08));
        exp_b_q.push_back(model_write(8'h08, 32'hA5A5A5A5, 4'hF));
        awaddr = 8'h08; wdata = 32'hA5A5A5A5; wstrb = 4'hF; araddr = 8'h08;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("coll_bvalid", 64'(bvalid), 64'd1);
        check("coll_rvalid", 64'(rvalid), 64'd1);
        er = exp_r_q.pop_front();
        eb = exp_b_q.pop_front();
        check("coll_old_read", 64'({rresp, rdata}), 64'(er));
        check("coll_bresp", 64'(bresp), 64'(eb));
        check("coll_reg2", 64'(regs[95:64]), 64'hA5A5A5A5);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        check("coll_done", 64'({bvalid, rvalid}), 64'd0);
        do_read(8'h08, 0);

        // reset while rvalid is high
        exp_r_q.push_back(model_read(8'h04));
        araddr = 8'h04; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("mid_rvalid", 64'(rvalid), 64'd1);
        er = exp_r_q.pop_front();
        check("mid_rdata", 64'({rresp, rdata}), 64'(er));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 64'(rvalid), 64'd0);
        check("mid_rst_rdata", 64'(rdata), 64'd0);
        for (int k = 0; k < NR; k++) model_q[k] = '0;
        check_regs("mid_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_readies", 64'({awready, wready, arready}), 64'd7);
        for (int k = 0; k < NR; k++) do_read(AW'(k * 4), 0);

        check("queues_drained", 64'(exp_b_q.size() + exp_r_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
